// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and widths for the MDU.
// Optional divider is selected by the MDU_DIV_EN macro.
package mdu_pkg;

    localparam int MDU_W     = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mduOp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREP    = 3'd1,
        MUL_RUN = 3'd2,
        DIV_RUN = 3'd3,
        FIX     = 3'd4
    } mduState_e;

    function automatic logic [MDU_W-1:0] absVal(
        input logic [MDU_W-1:0] v,
        input logic             sgn
    );
        return (sgn && v[MDU_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one iteration of unsigned shift-add multiply or restoring divide.
// The divide step exists only when MDU_DIV_EN is defined.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                 divMode,
    input  logic [2*MDU_W-1:0]   acc,
    input  logic [MDU_W-1:0]     opnd,
    output logic [2*MDU_W-1:0]   accNext
);

    logic [2*MDU_W-1:0] mulNext;
    logic [2*MDU_W-1:0] divNext;
    logic [2*MDU_W-1:0] p;
    logic [MDU_W:0]     sum;

    // multiply: acc = {partial product, remaining multiplier bits}
    always_comb begin
        p   = acc;
        sum = '0;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            sum = {1'b0, p[2*MDU_W-1:MDU_W]} + (p[0] ? {1'b0, opnd} : '0);
            p   = {sum, p[MDU_W-1:1]};
        end
        mulNext = p;
    end

`ifdef MDU_DIV_EN
    logic [MDU_W:0]   shifted;
    logic [MDU_W-1:0] diff;
    logic             ge;

    // divide: acc = {remainder, dividend shifting into quotient}
    always_comb begin
        shifted = {acc[2*MDU_W-1:MDU_W], acc[MDU_W-1]};
        ge      = (shifted >= {1'b0, opnd});
        diff    = shifted[MDU_W-1:0] - opnd;
        divNext = {ge ? diff : shifted[MDU_W-1:0], acc[MDU_W-2:0], ge};
    end
`else
    assign divNext = acc;
`endif

    assign accNext = divMode ? divNext : mulNext;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MDU controller owning FSM, HI/LO and sign fix-up.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU flag illegal.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [MDU_W-1:0] op_a,
    input  logic [MDU_W-1:0] op_b,
    input  logic             cancel,
    output logic             ex_stall,
    output logic             busy,
    output logic [MDU_W-1:0] rd_data,
    output logic [MDU_W-1:0] hi,
    output logic [MDU_W-1:0] lo,
    output logic             illegal
);

`ifdef MDU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    localparam int         MUL_ITERS = MDU_W / MUL_BITS_PER_CYCLE;
    localparam logic [4:0] MUL_LAST  = 5'(MUL_ITERS - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

    mduState_e          state, stateNext;
    logic [2*MDU_W-1:0] acc, accNext, prod;
    logic [MDU_W-1:0]   opnd, aAbs, bAbs, quo, rem;
    logic [4:0]         cnt;
    logic               isDiv, isSigned, negRes, negRem, divZero;
    logic               accept, opIsMul, opIsDiv, opIter;

    assign busy     = (state != IDLE);
    assign ex_stall = op_valid & busy;
    assign accept   = op_valid & ~ex_stall & ~cancel;

    assign opIsMul = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign opIsDiv = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign opIter  = opIsMul | (opIsDiv & DIV_EN);

    assign aAbs = absVal(acc[2*MDU_W-1:MDU_W], isSigned);
    assign bAbs = absVal(acc[MDU_W-1:0], isSigned);
    assign prod = negRes ? -acc : acc;
    assign quo  = negRes ? -acc[MDU_W-1:0] : acc[MDU_W-1:0];
    assign rem  = negRem ? -acc[2*MDU_W-1:MDU_W] : acc[2*MDU_W-1:MDU_W];

    assign rd_data = (op_code == OP_MFHI) ? hi :
                     (op_code == OP_MFLO) ? lo : '0;

    mdu_iter_core #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_core (
        .divMode (isDiv),
        .acc     (acc),
        .opnd    (opnd),
        .accNext (accNext)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // next-state: cancel aborts any op in flight
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept && opIter) stateNext = PREP;
            PREP:    stateNext = isDiv ? DIV_RUN : MUL_RUN;
            MUL_RUN: if (cnt == MUL_LAST) stateNext = FIX;
            DIV_RUN: if (cnt == DIV_LAST) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (cancel && state != IDLE) stateNext = IDLE;
    end

    // datapath: operand capture, magnitude prep, iteration, HI/LO writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            isDiv    <= 1'b0;
            isSigned <= 1'b0;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            divZero  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= accept & opIsDiv & ~DIV_EN;
            case (state)
                IDLE: if (accept) begin
                    if (op_code == OP_MTHI) hi <= op_a;
                    if (op_code == OP_MTLO) lo <= op_a;
                    if (opIter) begin
                        acc      <= {op_a, op_b};
                        isDiv    <= opIsDiv & DIV_EN;
                        isSigned <= (op_code == OP_MULT) || (op_code == OP_DIV);
                    end
                end
                PREP: begin
                    acc     <= {{MDU_W{1'b0}}, aAbs};
                    opnd    <= bAbs;
                    negRes  <= isSigned & (acc[2*MDU_W-1] ^ acc[MDU_W-1]);
                    negRem  <= isSigned & acc[2*MDU_W-1];
                    divZero <= (acc[MDU_W-1:0] == '0);
                    cnt     <= '0;
                end
                MUL_RUN, DIV_RUN: begin
                    acc <= accNext;
                    cnt <= cnt + 5'd1;
                end
                FIX: if (!cancel) begin
                    if (isDiv) begin
                        hi <= rem;
                        lo <= divZero ? '1 : quo;
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of mdu_ctrl (MUL_BITS_PER_CYCLE=1).
// Divide or illegal-op checks follow the MDU_DIV_EN build.
module tb_mdu_ctrl;
    import mdu_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, op_valid, cancel;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        ex_stall, busy, illegal;
    logic [31:0] rd_data, hi, lo;

    int checks = 0;
    int errors = 0;
    int n, stalls;
    logic [2:0] longOp;

    mdu_ctrl #(.MUL_BITS_PER_CYCLE(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .cancel   (cancel),
        .ex_stall (ex_stall),
        .busy     (busy),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        step();
        op_valid = 1'b0;
    endtask

    task automatic runToIdle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; cancel = 1'b0;
        op_code = OP_MFHI; op_a = '0; op_b = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;

        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_busy_after_accept", 32'(busy), 32'd1);
        runToIdle(n);
        chk("mult_busy_cycles", n, 32'd34);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        issue(OP_MULT, 32'h80000000, 32'h80000000);
        runToIdle(n);
        chk("mult_min_hi", hi, 32'h40000000);
        chk("mult_min_lo", lo, 32'h00000000);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runToIdle(n);
        chk("multu_max_hi", hi, 32'hFFFFFFFE);
        chk("multu_max_lo", lo, 32'h00000001);

        if (DIV_EN) begin
            issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
            chk("div_no_illegal", 32'(illegal), 32'd0);
            runToIdle(n);
            chk("div_busy_cycles", n, 32'd34);
            chk("div_lo", lo, 32'hFFFFFFFD);
            chk("div_hi", hi, 32'hFFFFFFFF);

            issue(OP_DIVU, 32'd7, 32'd0);
            runToIdle(n);
            chk("divu_zero_hi", hi, 32'd7);
            chk("divu_zero_lo", lo, 32'hFFFFFFFF);

            issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
            runToIdle(n);
            chk("div_ovf_lo", lo, 32'h80000000);
            chk("div_ovf_hi", hi, 32'h00000000);
        end else begin
            issue(OP_DIV, 32'd100, 32'd7);
            chk("nodiv_illegal", 32'(illegal), 32'd1);
            chk("nodiv_busy", 32'(busy), 32'd0);
            chk("nodiv_hi", hi, 32'hFFFFFFFE);
            chk("nodiv_lo", lo, 32'h00000001);
            step();
            chk("nodiv_illegal_pulse", 32'(illegal), 32'd0);
        end

        issue(OP_MULTU, 32'h00010000, 32'h00010001);
        op_valid = 1'b1;
        op_code  = OP_MFLO;
        #1;
        n = 0;
        stalls = 0;
        while (busy && n < 100) begin
            n++;
            if (ex_stall) stalls++;
            step();
        end
        chk("mflo_busy_cycles", n, 32'd34);
        chk("mflo_stall_cycles", stalls, 32'd34);
        chk("mflo_idle_stall", 32'(ex_stall), 32'd0);
        chk("mflo_rd", rd_data, 32'h00010000);
        chk("multu_hi", hi, 32'h00000001);
        step();
        op_valid = 1'b0;
        chk("mflo_no_busy", 32'(busy), 32'd0);

        op_valid = 1'b1;
        op_code  = OP_MTHI;
        op_a     = 32'h12345678;
        #1;
        chk("mthi_stall", 32'(ex_stall), 32'd0);
        step();
        chk("mthi_busy", 32'(busy), 32'd0);
        op_code = OP_MFHI;
        #1;
        chk("mfhi_stall", 32'(ex_stall), 32'd0);
        chk("mfhi_rd", rd_data, 32'h12345678);
        step();
        op_code = OP_MTLO;
        op_a    = 32'hCAFEF00D;
        step();
        op_code = OP_MFLO;
        #1;
        chk("mflo_after_mtlo", rd_data, 32'hCAFEF00D);
        step();
        op_valid = 1'b0;

        op_valid = 1'b1;
        op_code  = OP_MTHI;
        op_a     = 32'hDEADBEEF;
        cancel   = 1'b1;
        step();
        op_valid = 1'b0;
        cancel   = 1'b0;
        chk("cancel_blocks_mthi", hi, 32'h12345678);

        longOp = DIV_EN ? OP_DIV : OP_MULT;
        issue(longOp, 32'd100, 32'd7);
        repeat (10) step();
        chk("cancel_busy_before", 32'(busy), 32'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_idle", 32'(busy), 32'd0);
        chk("cancel_hi", hi, 32'h12345678);
        chk("cancel_lo", lo, 32'hCAFEF00D);
        repeat (30) step();
        chk("cancel_hi_later", hi, 32'h12345678);
        chk("cancel_lo_later", lo, 32'hCAFEF00D);

        issue(longOp, 32'd100, 32'd7);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        op_code = OP_MFLO;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stall", 32'(ex_stall), 32'd0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_rd", rd_data, 32'h0);

        issue(OP_MULTU, 32'd6, 32'd7);
        runToIdle(n);
        chk("recover_cycles", n, 32'd34);
        chk("recover_hi", hi, 32'h0);
        chk("recover_lo", lo, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
